gs_divider_seq: RTL and testbench

- Parametrised, iterative Goldschmidt divider for the team's packed sign/exponent/mantissa float format. It replaces the unrolled, combinational three-stage divider.
- One shared pair of multipliers runs a programmable number of iterations, one iteration per cycle, under a start/valid handshake.
- Sits beside the existing Booth multiplier path as the datapath divide unit.

---
 rtl/gs_divider_seq.sv | 167 ++++++++++++++++
 tb/tb_gs_divider_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/gs_divider_seq.sv
// Iterative Goldschmidt divider: one shared N/D multiplier pair, one iteration per cycle.
// Latency ITER+2 cycles (zero operands 1 cycle); start is ignored while busy and never queued.
module gs_divider_seq #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 7,
  parameter int ITER  = 3,
  parameter int GUARD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   valid,
  output logic [EXP_W+MAN_W:0]   q,
  output logic                   div0,
  output logic                   ovf,
  output logic                   unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int FW = 1 + MAN_W + GUARD;
  localparam int NW = FW + 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = 4;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_NORM} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d, d_q, d_d;
  logic [EW-1:0]   e_q, e_d;
  logic            s_q, s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_d, div0_d, ovf_d, unf_d;
  logic [W-1:0]    q_d;

  fp_t             fa, fb;
  logic            a_zero, b_zero;
  logic [NW:0]     f;
  logic [2*NW:0]   prod_n, prod_d;
  logic [NW-1:0]   n_mul, d_mul;
  logic [NW-1:0]   n_norm;
  logic [EW-1:0]   e_adj, e_r;
  logic [NW:0]     rnd;
  logic            rnd_carry;
  logic [MAN_W-1:0] man_r;
  logic            res_ovf, res_unf;

  assign fa     = a;
  assign fb     = b;
  assign a_zero = (a[W-2:0] == '0);
  assign b_zero = (b[W-2:0] == '0);

  // F = 2 - D needs one extra integer bit; 2.0 sits at bit NW.
  assign f      = {1'b1, {NW{1'b0}}} - {1'b0, d_q};
  assign prod_n = {{(NW+1){1'b0}}, n_q} * {{NW{1'b0}}, f};
  assign prod_d = {{(NW+1){1'b0}}, d_q} * {{NW{1'b0}}, f};
  assign n_mul  = NW'(prod_n >> FW);
  assign d_mul  = NW'(prod_d >> FW);

  assign n_norm    = n_q[FW] ? n_q : (n_q << 1);
  assign e_adj     = n_q[FW] ? e_q : (e_q - EW'(1));
  // Half an ULP of the stored mantissa sits at bit GUARD; 2.0 at bit NW means carry-out.
  assign rnd       = {1'b0, n_norm} + ((NW+1)'(1) << GUARD);
  assign rnd_carry = rnd[NW];
  assign man_r     = rnd_carry ? '0 : MAN_W'(rnd >> (FW - MAN_W));
  assign e_r       = e_adj + EW'(rnd_carry);
  assign res_unf   = e_r[EW-1];
  assign res_ovf   = !e_r[EW-1] && e_r[EXP_W];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    e_d     = e_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    q_d     = q;
    div0_d  = div0;
    ovf_d   = ovf;
    unf_d   = unf;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          div0_d = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          s_d    = fa.s ^ fb.s;
          if (b_zero) begin
            q_d     = {fa.s ^ fb.s, {(W-1){1'b1}}};
            div0_d  = 1'b1;
            valid_d = 1'b1;
          end else if (a_zero) begin
            q_d     = '0;
            valid_d = 1'b1;
          end else begin
            n_d     = {2'b01, fa.m, {GUARD{1'b0}}};
            d_d     = {2'b01, fb.m, {GUARD{1'b0}}};
            e_d     = {2'b00, fa.e} - {2'b00, fb.e} + EW'(BIAS);
            cnt_d   = '0;
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        n_d   = n_mul;
        d_d   = d_mul;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = ST_NORM;
      end
      ST_NORM: begin
        valid_d = 1'b1;
        state_d = ST_IDLE;
        if (res_ovf) begin
          q_d   = {s_q, {(W-1){1'b1}}};
          ovf_d = 1'b1;
        end else if (res_unf) begin
          q_d   = '0;
          unf_d = 1'b1;
        end else begin
          q_d = {s_q, e_r[EXP_W-1:0], man_r};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      valid   <= 1'b0;
      q       <= '0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      e_q     <= e_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      valid   <= valid_d;
      q       <= q_d;
      div0    <= div0_d;
      ovf     <= ovf_d;
      unf     <= unf_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gs_divider_seq.sv
// Directed-vector bench for gs_divider_seq with hand-computed quotients.
module tb_gs_divider_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, valid, div0, ovf, unf;
  logic [7:0] q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gs_divider_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .valid(valid), .q(q), .div0(div0), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eq, input logic [2:0] eflags, input int elat);
    int lat = 0;
    int nbusy = 0;
    @(posedge clk); #1 a = av; b = bv; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; a = ~av; b = ~bv;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (valid) begin
        lat = c;
        break;
      end
      if (busy) nbusy++;
    end
    chk({tag, ":latency"}, lat, elat);
    chk({tag, ":q"}, q, eq);
    chk({tag, ":div0/ovf/unf"}, {div0, ovf, unf}, eflags);
    chk({tag, ":busy_cycles"}, nbusy, elat - 1);
    chk({tag, ":busy_at_valid"}, busy, 0);
    @(negedge clk);
    chk({tag, ":valid_one_cycle"}, valid, 0);
  endtask

  initial begin
    int pulses;
    logic [7:0] cap_q;
    logic       cap_div0;

    #1 rst = 1'b1;
    #2;
    chk("reset:outputs", {busy, valid, q, div0, ovf, unf}, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_op("6/2",        8'h4C, 8'h40, 8'h44, 3'b000, 5);
    run_op("6/3",        8'h4C, 8'h44, 8'h40, 3'b000, 5);
    run_op("-6/2",       8'hCC, 8'h40, 8'hC4, 3'b000, 5);
    run_op("1/3",        8'h38, 8'h44, 8'h2B, 3'b000, 5);
    run_op("div0",       8'h38, 8'h00, 8'h7F, 3'b100, 1);
    run_op("zero_a",     8'h80, 8'h40, 8'h00, 3'b000, 1);
    run_op("overflow",   8'h78, 8'h08, 8'h7F, 3'b010, 5);
    run_op("underflow",  8'h08, 8'h78, 8'h00, 3'b001, 5);

    // A start raised mid-operation (with a divide-by-zero operand) must be dropped.
    pulses = 0; cap_q = '0; cap_div0 = 1'b0;
    @(posedge clk); #1 a = 8'h4C; b = 8'h40; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 a = 8'h38; b = 8'h00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        cap_q = q;
        cap_div0 = div0;
      end
    end
    chk("busy_start:pulses", pulses, 1);
    chk("busy_start:q", cap_q, 8'h44);
    chk("busy_start:div0", cap_div0, 0);

    // Asynchronous reset in the middle of an ITER cycle.
    @(posedge clk); #1 a = 8'h38; b = 8'h44; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("mid_reset:busy", busy, 0);
    chk("mid_reset:valid", valid, 0);
    chk("mid_reset:q", q, 0);
    chk("mid_reset:flags", {div0, ovf, unf}, 0);
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("mid_reset:no_valid", pulses, 0);

    run_op("after_reset", 8'h4C, 8'h40, 8'h44, 3'b000, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
